i2c_reg_arbiter: RTL and testbench

Shares one `i2c_master` command/data stream pair among `N_REQ` register-level requesters, such as the touch-sensor poller and the configuration loader. Each request is a single-byte register write or read. The block grants requests round-robin and expands each into the correct `i2c_master` command/data sequence. It then returns one response per request, tagged with the requester index, and sits directly between the requesters and `i2c_master`.

---
 rtl/i2c_reg_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_reg_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_arbiter.sv
// Round-robin arbiter that turns single-byte register reads/writes into i2c_master cmd/data beats.
// Optional read/write completion timeout under `I2C_ARB_TIMEOUT_EN`.
module i2c_reg_arbiter #(
  parameter int          N_REQ   = 2,
  parameter logic [23:0] TIMEOUT = 24'd270000,
  localparam int         IW      = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_read,
  input  logic [7*N_REQ-1:0] req_dev,
  input  logic [8*N_REQ-1:0] req_reg,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [IW-1:0]      rsp_id,
  output logic [7:0]         rsp_rdata,
  output logic               rsp_err,
  input  logic               rsp_ready,
  output logic [6:0]         m_cmd_address,
  output logic               m_cmd_start,
  output logic               m_cmd_read,
  output logic               m_cmd_write,
  output logic               m_cmd_write_multiple,
  output logic               m_cmd_stop,
  output logic               m_cmd_valid,
  input  logic               m_cmd_ready,
  output logic [7:0]         m_data_tdata,
  output logic               m_data_tvalid,
  output logic               m_data_tlast,
  input  logic               m_data_tready,
  input  logic [7:0]         s_rx_tdata,
  input  logic               s_rx_tvalid,
  output logic               s_rx_tready,
  input  logic               i2c_busy
);

  typedef enum logic [3:0] {
    IDLE, W_CMD, W_REG, W_VAL, W_DONE, R_ACMD, R_REG, R_RCMD, R_WAIT, RESP
  } state_t;

  // Command flag sets, ordered {start, read, write, write_multiple, stop}.
  localparam logic [4:0] F_WMULT = 5'b10011;
  localparam logic [4:0] F_RADDR = 5'b10100;
  localparam logic [4:0] F_RDATA = 5'b11001;

  state_t             state, state_d;
  logic [IW-1:0]      rr_ptr, rr_ptr_d;
  logic [IW-1:0]      gnt;
  logic               found;
  int                 idx;
  logic [7:0]         reg_q, reg_d, wdata_q, wdata_d;
  logic [4:0]         cmd_flg, cmd_flg_d;
  logic [N_REQ-1:0]   req_ready_d;
  logic               cmd_vld_d, dat_vld_d, dat_last_d, rsp_vld_d, rx_rdy_d;
  logic [6:0]         cmd_addr_d;
  logic [7:0]         dat_d, rsp_dat_d;
  logic [IW-1:0]      rsp_id_d;

  assign {m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop} = cmd_flg;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [23:0] tmo_cnt;
  logic        tmo_hit;
  logic        rsp_err_d;

  assign tmo_hit = (tmo_cnt >= TIMEOUT);

  // Counter is zero on the first cycle of either wait state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      tmo_cnt <= (state == R_WAIT || state == W_DONE) ? tmo_cnt + 24'd1 : '0;
      rsp_err <= rsp_err_d;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    req_ready_d = '0;
    cmd_vld_d   = m_cmd_valid;
    cmd_flg_d   = cmd_flg;
    cmd_addr_d  = m_cmd_address;
    dat_d       = m_data_tdata;
    dat_vld_d   = m_data_tvalid;
    dat_last_d  = m_data_tlast;
    rsp_vld_d   = rsp_valid;
    rsp_id_d    = rsp_id;
    rsp_dat_d   = rsp_rdata;
`ifdef I2C_ARB_TIMEOUT_EN
    rsp_err_d   = rsp_err;
`endif

    found = 1'b0;
    gnt   = rr_ptr;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = IW'(idx);
      end
    end

    case (state)
      IDLE: if (found) begin
        rsp_id_d         = gnt;
        reg_d            = req_reg[gnt*8 +: 8];
        wdata_d          = req_wdata[gnt*8 +: 8];
        req_ready_d[gnt] = 1'b1;
        rr_ptr_d         = (gnt == IW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
        cmd_vld_d        = 1'b1;
        cmd_addr_d       = req_dev[gnt*7 +: 7];
        if (req_read[gnt]) begin
          cmd_flg_d = F_RADDR;
          state_d   = R_ACMD;
        end else begin
          cmd_flg_d = F_WMULT;
          state_d   = W_CMD;
        end
      end
      W_CMD: if (m_cmd_ready) begin
        cmd_vld_d  = 1'b0;
        dat_vld_d  = 1'b1;
        dat_d      = reg_q;
        dat_last_d = 1'b0;
        state_d    = W_REG;
      end
      W_REG: if (m_data_tready) begin
        dat_d      = wdata_q;
        dat_last_d = 1'b1;
        state_d    = W_VAL;
      end
      W_VAL: if (m_data_tready) begin
        dat_vld_d  = 1'b0;
        dat_last_d = 1'b0;
        state_d    = W_DONE;
      end
      W_DONE: begin
        if (!i2c_busy) begin
          rsp_vld_d = 1'b1;
          rsp_dat_d = 8'h00;
`ifdef I2C_ARB_TIMEOUT_EN
          rsp_err_d = 1'b0;
        end else if (tmo_hit) begin
          rsp_vld_d = 1'b1;
          rsp_dat_d = 8'h00;
          rsp_err_d = 1'b1;
`endif
        end
        if (rsp_vld_d) state_d = RESP;
      end
      R_ACMD: if (m_cmd_ready) begin
        cmd_vld_d  = 1'b0;
        dat_vld_d  = 1'b1;
        dat_d      = reg_q;
        dat_last_d = 1'b1;
        state_d    = R_REG;
      end
      R_REG: if (m_data_tready) begin
        dat_vld_d  = 1'b0;
        dat_last_d = 1'b0;
        cmd_vld_d  = 1'b1;
        cmd_flg_d  = F_RDATA;
        state_d    = R_RCMD;
      end
      R_RCMD: if (m_cmd_ready) begin
        cmd_vld_d = 1'b0;
        state_d   = R_WAIT;
      end
      R_WAIT: begin
        if (s_rx_tvalid && s_rx_tready) begin
          rsp_vld_d = 1'b1;
          rsp_dat_d = s_rx_tdata;
`ifdef I2C_ARB_TIMEOUT_EN
          rsp_err_d = 1'b0;
        end else if (tmo_hit) begin
          rsp_vld_d = 1'b1;
          rsp_dat_d = 8'h00;
          rsp_err_d = 1'b1;
`endif
        end
        if (rsp_vld_d) state_d = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_vld_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Rx is only back-pressured while a response waits; stray bytes elsewhere are swallowed.
    rx_rdy_d = (state_d != RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      reg_q         <= '0;
      wdata_q       <= '0;
      req_ready     <= '0;
      cmd_flg       <= '0;
      m_cmd_valid   <= 1'b0;
      m_cmd_address <= '0;
      m_data_tdata  <= '0;
      m_data_tvalid <= 1'b0;
      m_data_tlast  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_rdata     <= '0;
      s_rx_tready   <= 1'b0;
    end else begin
      state         <= state_d;
      rr_ptr        <= rr_ptr_d;
      reg_q         <= reg_d;
      wdata_q       <= wdata_d;
      req_ready     <= req_ready_d;
      cmd_flg       <= cmd_flg_d;
      m_cmd_valid   <= cmd_vld_d;
      m_cmd_address <= cmd_addr_d;
      m_data_tdata  <= dat_d;
      m_data_tvalid <= dat_vld_d;
      m_data_tlast  <= dat_last_d;
      rsp_valid     <= rsp_vld_d;
      rsp_id        <= rsp_id_d;
      rsp_rdata     <= rsp_dat_d;
      s_rx_tready   <= rx_rdy_d;
    end
  end

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Directed vector bench for i2c_reg_arbiter: table of transactions plus reset-abort and timeout sequences.
module tb_i2c_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0, req_read = '0, req_ready;
  logic [13:0] req_dev = '0;
  logic [15:0] req_reg = '0, req_wdata = '0;
  logic        rsp_valid, rsp_err, rsp_ready = 1'b0;
  logic [0:0]  rsp_id;
  logic [7:0]  rsp_rdata;
  logic [6:0]  m_cmd_address;
  logic        m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop, m_cmd_valid;
  logic        m_cmd_ready = 1'b0;
  logic [7:0]  m_data_tdata;
  logic        m_data_tvalid, m_data_tlast, m_data_tready = 1'b0;
  logic [7:0]  s_rx_tdata = '0;
  logic        s_rx_tvalid = 1'b0, s_rx_tready;
  logic        i2c_busy = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  i2c_reg_arbiter #(.N_REQ(2), .TIMEOUT(24'd100)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_read(req_read), .req_dev(req_dev), .req_reg(req_reg),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready),
    .m_cmd_address(m_cmd_address), .m_cmd_start(m_cmd_start), .m_cmd_read(m_cmd_read),
    .m_cmd_write(m_cmd_write), .m_cmd_write_multiple(m_cmd_write_multiple),
    .m_cmd_stop(m_cmd_stop), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_data_tdata(m_data_tdata), .m_data_tvalid(m_data_tvalid), .m_data_tlast(m_data_tlast),
    .m_data_tready(m_data_tready),
    .s_rx_tdata(s_rx_tdata), .s_rx_tvalid(s_rx_tvalid), .s_rx_tready(s_rx_tready),
    .i2c_busy(i2c_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mask;  bit hold;  bit stall;
    logic [1:0]  rd;    logic [13:0] dev;  logic [15:0] rg;  logic [15:0] wd;  logic [7:0] rx;
    logic [1:0]  gnt;   logic [6:0]  addr; logic [4:0]  cmd1; logic [7:0] d0;  logic l0;
    logic [7:0]  d1;    logic [4:0]  cmd2; logic [7:0]  rdata;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop};
  endfunction

  task automatic get_cmd(input bit stall, output logic [6:0] addr, output logic [4:0] flg);
    logic [11:0] prev = 'x;
    bit seen = 0, r;
    int n = 0;
    forever begin
      if (seen) chk("cmd_hold", {m_cmd_valid, m_cmd_address, flags()}, {1'b1, prev});
      else if (m_cmd_valid) seen = 1;
      prev = {m_cmd_address, flags()};
      r = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
      m_cmd_ready = r;
      @(posedge clk); #1;
      n++;
      if (seen && r) break;
      if (n > 200) begin chk("cmd_timeout", 0, 1); break; end
    end
    m_cmd_ready = 1'b0;
    {addr, flg} = prev;
  endtask

  task automatic get_dat(input bit stall, output logic [7:0] d, output logic l);
    logic [8:0] prev = 'x;
    bit seen = 0, r;
    int n = 0;
    forever begin
      if (seen) chk("data_hold", {m_data_tvalid, m_data_tdata, m_data_tlast}, {1'b1, prev});
      else if (m_data_tvalid) seen = 1;
      prev = {m_data_tdata, m_data_tlast};
      r = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
      m_data_tready = r;
      @(posedge clk); #1;
      n++;
      if (seen && r) break;
      if (n > 200) begin chk("data_timeout", 0, 1); break; end
    end
    m_data_tready = 1'b0;
    {d, l} = prev;
  endtask

  task automatic get_rsp(input bit stall, output logic id, output logic [7:0] rd, output logic e);
    logic [9:0] prev = 'x;
    bit seen = 0, r;
    int n = 0;
    forever begin
      if (seen) chk("rsp_hold", {rsp_valid, rsp_id, rsp_rdata, rsp_err}, {1'b1, prev});
      else if (rsp_valid) seen = 1;
      prev = {rsp_id, rsp_rdata, rsp_err};
      r = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
      rsp_ready = r;
      @(posedge clk); #1;
      n++;
      if (seen && r) break;
      if (n > 400) begin chk("rsp_timeout", 0, 1); break; end
    end
    rsp_ready = 1'b0;
    {id, rd, e} = prev;
  endtask

  task automatic wait_grant(input logic [1:0] exp, input bit hold);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (req_ready == 2'b00 && n < 50);
    chk("grant", req_ready, exp);
    chk("cmd_with_grant", m_cmd_valid, 1'b1);
    if (!hold) req_valid = 2'b00;
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    logic [6:0] a; logic [4:0] f; logic [7:0] d; logic l, id, e; logic [7:0] rd;
    bit is_rd;
    req_valid = v.mask; req_read = v.rd; req_dev = v.dev; req_reg = v.rg; req_wdata = v.wd;
    is_rd = v.rd[v.gnt[1]];
    wait_grant(v.gnt, v.hold);
    get_cmd(v.stall, a, f);
    chk($sformatf("v%0d_cmd1_addr", vi), a, v.addr);
    chk($sformatf("v%0d_cmd1_flags", vi), f, v.cmd1);
    get_dat(v.stall, d, l);
    chk($sformatf("v%0d_beat0", vi), {d, l}, {v.d0, v.l0});
    if (!is_rd) begin
      get_dat(v.stall, d, l);
      chk($sformatf("v%0d_beat1", vi), {d, l}, {v.d1, 1'b1});
      i2c_busy = 1'b1;
      s_rx_tvalid = 1'b1; s_rx_tdata = 8'hEE;
      chk("rx_ready_wdone", s_rx_tready, 1'b1);
      @(posedge clk); #1;
      s_rx_tvalid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("rsp_early_busy", rsp_valid, 1'b0);
      i2c_busy = 1'b0;
      @(posedge clk); #1;
    end else begin
      get_cmd(v.stall, a, f);
      chk($sformatf("v%0d_cmd2", vi), {a, f}, {v.addr, v.cmd2});
      repeat (2) begin @(posedge clk); #1; end
      chk("rsp_early_rx", rsp_valid, 1'b0);
      s_rx_tvalid = 1'b1; s_rx_tdata = v.rx;
      chk("rx_ready_rwait", s_rx_tready, 1'b1);
      @(posedge clk); #1;
      s_rx_tvalid = 1'b0;
      chk("rx_ready_resp", s_rx_tready, 1'b0);
    end
    chk($sformatf("v%0d_rsp_latency", vi), rsp_valid, 1'b1);
    get_rsp(v.stall, id, rd, e);
    chk($sformatf("v%0d_rsp", vi), {id, rd, e}, {v.gnt[1], v.rdata, 1'b0});
  endtask

  initial begin
    logic [6:0] a; logic [4:0] f; logic [7:0] d; logic l;

    vt[0]  = '{mask:2'b01, hold:0, stall:0, rd:2'b00, dev:{7'h00, 7'h5A}, rg:{8'h00, 8'h5E},
               wd:{8'h00, 8'h0F}, rx:8'h00, gnt:2'b01, addr:7'h5A, cmd1:5'b10011, d0:8'h5E, l0:0,
               d1:8'h0F, cmd2:5'b00000, rdata:8'h00};
    vt[1]  = '{mask:2'b10, hold:0, stall:0, rd:2'b10, dev:{7'h50, 7'h00}, rg:{8'h00, 8'h00},
               wd:16'h0000, rx:8'h21, gnt:2'b10, addr:7'h50, cmd1:5'b10100, d0:8'h00, l0:1,
               d1:8'h00, cmd2:5'b11001, rdata:8'h21};
    vt[2]  = '{mask:2'b11, hold:1, stall:0, rd:2'b10, dev:{7'h44, 7'h11}, rg:{8'h55, 8'h22},
               wd:{8'h00, 8'h33}, rx:8'h66, gnt:2'b01, addr:7'h11, cmd1:5'b10011, d0:8'h22, l0:0,
               d1:8'h33, cmd2:5'b00000, rdata:8'h00};
    vt[3]  = '{mask:2'b11, hold:1, stall:0, rd:2'b10, dev:{7'h44, 7'h11}, rg:{8'h55, 8'h22},
               wd:{8'h00, 8'h33}, rx:8'h66, gnt:2'b10, addr:7'h44, cmd1:5'b10100, d0:8'h55, l0:1,
               d1:8'h00, cmd2:5'b11001, rdata:8'h66};
    vt[4]  = vt[2];
    vt[5]  = vt[3];
    vt[5].hold = 0;
    vt[6]  = '{mask:2'b10, hold:0, stall:1, rd:2'b00, dev:{7'h7F, 7'h00}, rg:{8'hFF, 8'h00},
               wd:{8'hA5, 8'h00}, rx:8'h00, gnt:2'b10, addr:7'h7F, cmd1:5'b10011, d0:8'hFF, l0:0,
               d1:8'hA5, cmd2:5'b00000, rdata:8'h00};
    vt[7]  = '{mask:2'b01, hold:0, stall:1, rd:2'b01, dev:{7'h00, 7'h01}, rg:{8'h00, 8'h80},
               wd:16'h0000, rx:8'hC3, gnt:2'b01, addr:7'h01, cmd1:5'b10100, d0:8'h80, l0:1,
               d1:8'h00, cmd2:5'b11001, rdata:8'hC3};
    // Pointer sits at 1 after requester 0 was served, so the tie goes to requester 1.
    vt[8]  = '{mask:2'b11, hold:0, stall:1, rd:2'b10, dev:{7'h3C, 7'h2B}, rg:{8'h0A, 8'h0B},
               wd:{8'h00, 8'h0C}, rx:8'h5A, gnt:2'b10, addr:7'h3C, cmd1:5'b10100, d0:8'h0A, l0:1,
               d1:8'h00, cmd2:5'b11001, rdata:8'h5A};
    vt[9]  = '{mask:2'b01, hold:0, stall:1, rd:2'b00, dev:{7'h00, 7'h2B}, rg:{8'h00, 8'h0B},
               wd:{8'h00, 8'h0C}, rx:8'h00, gnt:2'b01, addr:7'h2B, cmd1:5'b10011, d0:8'h0B, l0:0,
               d1:8'h0C, cmd2:5'b00000, rdata:8'h00};
    vt[10] = '{mask:2'b11, hold:0, stall:0, rd:2'b10, dev:{7'h40, 7'h12}, rg:{8'h01, 8'h34},
               wd:{8'h00, 8'h56}, rx:8'h00, gnt:2'b01, addr:7'h12, cmd1:5'b10011, d0:8'h34, l0:0,
               d1:8'h56, cmd2:5'b00000, rdata:8'h00};

    #12;
    chk("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, m_cmd_address, flags(),
        m_cmd_valid, m_data_tdata, m_data_tvalid, m_data_tlast, s_rx_tready}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rx_ready_idle", s_rx_tready, 1'b1);

    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    // Abort a write while its final data beat is on the bus.
    req_valid = 2'b01; req_read = 2'b00; req_dev = {7'h00, 7'h12};
    req_reg = {8'h00, 8'h34}; req_wdata = {8'h00, 8'h56};
    wait_grant(2'b01, 1'b0);
    get_cmd(1'b0, a, f);
    get_dat(1'b0, d, l);
    chk("wval_beat", {m_data_tvalid, m_data_tdata, m_data_tlast}, {1'b1, 8'h56, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, m_cmd_address, flags(),
        m_cmd_valid, m_data_tdata, m_data_tvalid, m_data_tlast, s_rx_tready}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(vt[10], 10);

`ifdef I2C_ARB_TIMEOUT_EN
    begin
      int n = 0;
      req_valid = 2'b10; req_read = 2'b10; req_dev = {7'h0A, 7'h00}; req_reg = {8'h0B, 8'h00};
      wait_grant(2'b10, 1'b0);
      get_cmd(1'b0, a, f);
      get_dat(1'b0, d, l);
      get_cmd(1'b0, a, f);
      while (!rsp_valid && n < 300) begin @(posedge clk); #1; n++; end
      chk("tmo_not_early", (n >= 100), 1'b1);
      chk("tmo_rsp", {rsp_valid, rsp_id, rsp_rdata, rsp_err}, {1'b1, 1'b1, 8'h00, 1'b1});
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      run_vec(vt[1], 11);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
